digi_ota_cal_ctrl: RTL
======================

DIGI_OTA_CAL_CTRL -- requirements
Module: digi_ota_cal_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start  input  1  calibration request, sampled each clock.
REQ-004 SHALL have port: abort  input  1  cancel an in-progress calibration.
REQ-005 SHALL have port: settle_cfg  input  4  settle cycles per trim step, value S; S>=2 required for valid results.
REQ-006 SHALL have port: cmp_in  input  1  digital OTA output, asynchronous to clk.
REQ-007 SHALL have port: trim  output  6  offset-trim code driven to the OTA.
REQ-008 SHALL have port: cal_mode  output  1  shorts OTA inputs for calibration; high exactly while busy.
REQ-009 SHALL have port: busy  output  1  calibration in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse on completion.
REQ-011 SHALL have port: trim_valid  output  1  trim holds a completed calibration result.

Function
REQ-012 SHALL pass cmp_in through a 2-flop synchronizer; only the second flop's output (cmp_s) SHALL be used.
REQ-013 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE + start=1 + abort=0 SHALL go to SETTLE: latch settle_cfg into S_reg, set bit index to 5, set trim=6'b100000, clear trim_valid.
REQ-015 On every entry to SETTLE, the settle counter SHALL load S_reg.
REQ-016 In SETTLE, the counter SHALL decrement each cycle; the state SHALL advance to SAMPLE in the cycle after the counter reads 0, giving S+1 cycles in SETTLE.
REQ-017 SAMPLE (1 cycle), at bit index i: if cmp_s=1, trim[i] SHALL clear; otherwise trim[i] SHALL be kept.
REQ-018 SAMPLE with i>0: trim[i-1] SHALL be set, index SHALL become i-1, and the state SHALL return to SETTLE.
REQ-019 SAMPLE with i=0 SHALL go to DONE.
REQ-020 DONE (1 cycle) SHALL assert done=1 and trim_valid=1, then go to IDLE.
REQ-021 trim_valid SHALL stay 1 until the next accepted start or abort.
REQ-022 busy and cal_mode SHALL be 1 in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-023 done SHALL rise exactly 6*(S+2)+1 clock edges after the edge that accepted start.
REQ-024 start while busy=1 or in DONE SHALL be ignored; there SHALL be no queuing.
REQ-025 abort in SETTLE or SAMPLE SHALL go to IDLE on the next edge with trim=6'b100000, trim_valid=0, and no done pulse.
REQ-026 abort in IDLE SHALL clear trim_valid and set trim=6'b100000.
REQ-027 When start and abort are both 1 in the same cycle, abort SHALL win and the start SHALL be discarded.
REQ-028 Changes to settle_cfg during a run SHALL have no effect until the next accepted start.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational input-to-output path.

Reset
REQ-030 While rst=1, immediately and without a clock: state=IDLE, trim=6'b100000, busy=0, cal_mode=0, done=0, trim_valid=0, synchronizer flops=0, counter=0, index=5.
REQ-031 Reset asserted mid-calibration SHALL abandon the run with no done pulse; operation SHALL resume only on a new start after rst deasserts.

Verification
REQ-032 S=3, cmp model cmp_in=(trim>=37) -> trim sequence 32,48->32,40->32,36,38->36,37->36; done at edge 31 after start; trim=36; trim_valid=1.
REQ-033 S=2, cmp_in held 0 -> trim=63 and done pulse; cmp_in held 1 -> trim=0 and done pulse.
REQ-034 S=3, abort asserted in the 3rd SETTLE -> next cycle IDLE, trim=32, busy=0, trim_valid=0, no done pulse.
REQ-035 start pulsed again while busy, and start+abort asserted together from IDLE -> both ignored; done timing unchanged in the first case, state stays IDLE in the second.
REQ-036 rst asserted asynchronously mid-SAMPLE -> outputs at reset values before the next clock edge; a new start after deassertion completes normally.
REQ-037 settle_cfg changed from 3 to 9 mid-run -> done still at edge 31.

Source files
------------

// File: rtl/digi_ota_cal_ctrl.sv
// Successive-approximation offset-trim controller for a digital-output OTA.
// Six-bit binary search, MSB first, with a programmable settle time per trim step.
module digi_ota_cal_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] settle_cfg,
    input  logic       cmp_in,
    output logic [5:0] trim,
    output logic       cal_mode,
    output logic       busy,
    output logic       done,
    output logic       trim_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [5:0] TRIM_MID = 6'b100000;

    state_t     state;
    logic [3:0] s_reg;
    logic [3:0] cnt;
    logic [2:0] idx;
    logic       sync1;
    logic       cmp_s;
    logic [5:0] trim_smp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            cmp_s <= 1'b0;
        end else begin
            sync1 <= cmp_in;
            cmp_s <= sync1;
        end
    end

    // Resolve the current bit from the comparator, then tentatively set the next lower bit.
    always_comb begin
        trim_smp = trim;
        if (cmp_s)
            trim_smp[idx] = 1'b0;
        if (idx != 3'd0)
            trim_smp[idx - 3'd1] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            s_reg      <= '0;
            cnt        <= '0;
            idx        <= 3'd5;
            trim       <= TRIM_MID;
            busy       <= 1'b0;
            cal_mode   <= 1'b0;
            done       <= 1'b0;
            trim_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (abort) begin
                        trim       <= TRIM_MID;
                        trim_valid <= 1'b0;
                    end else if (start) begin
                        s_reg      <= settle_cfg;
                        cnt        <= settle_cfg;
                        idx        <= 3'd5;
                        trim       <= TRIM_MID;
                        trim_valid <= 1'b0;
                        busy       <= 1'b1;
                        cal_mode   <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE, SAMPLE: begin
                    if (abort) begin
                        state      <= IDLE;
                        trim       <= TRIM_MID;
                        trim_valid <= 1'b0;
                        busy       <= 1'b0;
                        cal_mode   <= 1'b0;
                        idx        <= 3'd5;
                        cnt        <= '0;
                    end else if (state == SETTLE) begin
                        if (cnt == 4'd0)
                            state <= SAMPLE;
                        else
                            cnt <= cnt - 4'd1;
                    end else begin
                        trim <= trim_smp;
                        if (idx == 3'd0) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            cal_mode <= 1'b0;
                        end else begin
                            idx   <= idx - 3'd1;
                            cnt   <= s_reg;
                            state <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    done       <= 1'b1;
                    trim_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
